// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: state codes, opcodes,
// functs, ALU operations, trap causes and the bundle of datapath controls.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_WB_AL  = 4'd3,
        S_EXE_BR = 4'd4,
        S_EXE_LS = 4'd5,
        S_MEM    = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8,
        S_TRAP   = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU_R, CL_ALU_I, CL_BEQ, CL_BNE, CL_BLTZ, CL_LW, CL_SW,
        CL_J, CL_JAL, CL_JR, CL_HALT, CL_ILL
    } iclass_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_SLL = 3'd5
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_BUS  = 2'b01;
    localparam logic [1:0] CAUSE_ILL  = 2'b10;
    localparam logic [1:0] CAUSE_OVF  = 2'b11;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_R31 = 2'b00;
    localparam logic [1:0] RD_RT  = 2'b01;
    localparam logic [1:0] RD_RD  = 2'b10;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       pc_wre;
        logic       ir_wre;
        logic       reg_wre;
        logic       m_rd;
        logic       m_wr;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       db_data_src;
        logic       wr_reg_d_src;
        logic       ext_sel;
        logic       if_need_of;
        logic [1:0] reg_dst;
        logic [1:0] pc_src;
        alu_op_e    alu_op;
    } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/funct to instruction class and the
// per-instruction ALU controls that stay constant across EXE..WB.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_e    iclass,
    output alu_op_e    alu_op,
    output logic       ext_sel,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic       if_need_of,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path can leave one unassigned (no latch).
        iclass     = CL_ILL;
        alu_op     = ALU_ADD;
        ext_sel    = 1'b1;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        if_need_of = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                iclass = CL_ALU_R;
                case (funct)
                    FN_ADD:  begin alu_op = ALU_ADD; if_need_of = 1'b1; end
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB:  begin alu_op = ALU_SUB; if_need_of = 1'b1; end
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  begin alu_op = ALU_SLL; alu_src_a = 1'b1; end
                    FN_JR:   iclass = CL_JR;
                    default: iclass = CL_ILL;
                endcase
            end
            OP_ADDI: begin iclass = CL_ALU_I; alu_src_b = 1'b1; if_need_of = 1'b1; end
            OP_SLTI: begin iclass = CL_ALU_I; alu_src_b = 1'b1; alu_op = ALU_SLT; end
            // Logical immediates are zero-extended.
            OP_ANDI: begin iclass = CL_ALU_I; alu_src_b = 1'b1; alu_op = ALU_AND; ext_sel = 1'b0; end
            OP_ORI:  begin iclass = CL_ALU_I; alu_src_b = 1'b1; alu_op = ALU_OR;  ext_sel = 1'b0; end
            OP_BEQ:  begin iclass = CL_BEQ;  alu_op = ALU_SUB; end
            OP_BNE:  begin iclass = CL_BNE;  alu_op = ALU_SUB; end
            OP_BLTZ: begin iclass = CL_BLTZ; alu_op = ALU_SUB; end
            OP_LW:   begin iclass = CL_LW; alu_src_b = 1'b1; end
            OP_SW:   begin iclass = CL_SW; alu_src_b = 1'b1; end
            OP_J:    iclass = CL_J;
            OP_JAL:  iclass = CL_JAL;
            OP_HALT: iclass = CL_HALT;
            default: iclass = CL_ILL;
        endcase
    end

    assign illegal = (iclass == CL_ILL);

endmodule

// File: rtl/mc_sequencer.sv
// IF/ID/EXE/MEM/WB sequencer for the multi-cycle core with memory handshakes,
// bounded wait timeout, traps and HALT. Outputs are decoded from state and IR fields.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter bit TRAP_ON_OVF = 1'b1,
    parameter int ALUOP_W     = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               sign,
    input  logic               overflow,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               mRD,
    output logic               mWR,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               DBDataSrc,
    output logic               WrRegDSrc,
    output logic               ExtSel,
    output logic               ifNeedOf,
    output logic [1:0]         RegDst,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [3:0]         state,
    output logic               trap,
    output logic [1:0]         trap_cause
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;

    iclass_e dec_iclass;
    alu_op_e dec_alu_op;
    logic    dec_ext_sel, dec_src_a, dec_src_b, dec_need_of, dec_illegal;

    mc_decode u_decode (
        .opcode     (opcode),
        .funct      (funct),
        .iclass     (dec_iclass),
        .alu_op     (dec_alu_op),
        .ext_sel    (dec_ext_sel),
        .alu_src_a  (dec_src_a),
        .alu_src_b  (dec_src_b),
        .if_need_of (dec_need_of),
        .illegal    (dec_illegal)
    );

    logic waiting, timeout_hit, ovf_trap, br_taken;

    assign waiting     = ((state_q == S_IF) && !imem_ack) || ((state_q == S_MEM) && !dmem_ack);
    assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && (cnt_q == CNT_LIMIT);
    assign ovf_trap    = TRAP_ON_OVF && dec_need_of && overflow;

    always_comb begin
        case (dec_iclass)
            CL_BEQ:  br_taken = zero;
            CL_BNE:  br_taken = !zero;
            CL_BLTZ: br_taken = sign;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        trap_d  = trap_q;
        cause_d = cause_q;
        case (state_q)
            S_IF: begin
                if (imem_ack) begin
                    state_d = S_ID;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            S_ID: begin
                if (dec_illegal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILL;
                end else begin
                    case (dec_iclass)
                        CL_ALU_R, CL_ALU_I:       state_d = S_EXE_AL;
                        CL_BEQ, CL_BNE, CL_BLTZ:  state_d = S_EXE_BR;
                        CL_LW, CL_SW:             state_d = S_EXE_LS;
                        CL_J, CL_JAL, CL_JR:      state_d = S_IF;
                        CL_HALT:                  state_d = S_HALT;
                        default: begin
                            state_d = S_TRAP;
                            cause_d = CAUSE_ILL;
                        end
                    endcase
                end
            end
            S_EXE_AL: state_d = S_WB_AL;
            S_WB_AL: begin
                if (ovf_trap) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_OVF;
                end else begin
                    state_d = S_IF;
                end
            end
            S_EXE_BR: state_d = S_IF;
            S_EXE_LS: state_d = S_MEM;
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = (dec_iclass == CL_SW) ? S_IF : S_WB_LD;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            S_WB_LD: state_d = S_IF;
            default: state_d = state_q;
        endcase
        if (state_d == S_TRAP) trap_d = 1'b1;
        // Counter only advances while stalled; any state change leaves it at zero.
        if (waiting && !timeout_hit && (MEM_TIMEOUT != 0)) cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: non-blocking assignments here so every flop samples the pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IF;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    ctrl_t ctrl, ctrl_o;

    always_comb begin
        ctrl = '0;
        if (state_q inside {S_EXE_AL, S_WB_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_LD}) begin
            ctrl.alu_op    = dec_alu_op;
            ctrl.ext_sel   = dec_ext_sel;
            ctrl.alu_src_a = dec_src_a;
            ctrl.alu_src_b = dec_src_b;
        end
        if (state_q inside {S_EXE_AL, S_WB_AL}) ctrl.if_need_of = dec_need_of;
        case (state_q)
            S_IF: begin
                ctrl.imem_req = 1'b1;
                ctrl.ir_wre   = imem_ack;
            end
            S_ID: begin
                case (dec_iclass)
                    CL_J:   begin ctrl.pc_wre = 1'b1; ctrl.pc_src = PC_JUMP; end
                    CL_JAL: begin
                        ctrl.pc_wre       = 1'b1;
                        ctrl.pc_src       = PC_JUMP;
                        ctrl.reg_wre      = 1'b1;
                        ctrl.reg_dst      = RD_R31;
                        ctrl.wr_reg_d_src = 1'b0;
                    end
                    CL_JR:  begin ctrl.pc_wre = 1'b1; ctrl.pc_src = PC_RS; end
                    default: ;
                endcase
            end
            S_WB_AL: begin
                ctrl.reg_wre      = !ovf_trap;
                ctrl.pc_wre       = !ovf_trap;
                ctrl.wr_reg_d_src = 1'b1;
                ctrl.reg_dst      = (dec_iclass == CL_ALU_R) ? RD_RD : RD_RT;
            end
            S_EXE_BR: begin
                ctrl.pc_wre = 1'b1;
                ctrl.pc_src = br_taken ? PC_BRANCH : PC_SEQ;
            end
            S_MEM: begin
                ctrl.dmem_req = 1'b1;
                ctrl.m_rd     = (dec_iclass == CL_LW);
                ctrl.m_wr     = (dec_iclass == CL_SW);
            end
            S_WB_LD: begin
                ctrl.reg_wre      = 1'b1;
                ctrl.db_data_src  = 1'b1;
                ctrl.wr_reg_d_src = 1'b1;
                ctrl.reg_dst      = RD_RT;
                ctrl.pc_wre       = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset gates outputs combinationally so an abandoned memory access drops immediately.
    assign ctrl_o = RST ? ctrl : '0;

    assign imem_req   = ctrl_o.imem_req;
    assign dmem_req   = ctrl_o.dmem_req;
    assign PCWre      = ctrl_o.pc_wre;
    assign IRWre      = ctrl_o.ir_wre;
    assign RegWre     = ctrl_o.reg_wre;
    assign mRD        = ctrl_o.m_rd;
    assign mWR        = ctrl_o.m_wr;
    assign ALUSrcA    = ctrl_o.alu_src_a;
    assign ALUSrcB    = ctrl_o.alu_src_b;
    assign DBDataSrc  = ctrl_o.db_data_src;
    assign WrRegDSrc  = ctrl_o.wr_reg_d_src;
    assign ExtSel     = ctrl_o.ext_sel;
    assign ifNeedOf   = ctrl_o.if_need_of;
    assign RegDst     = ctrl_o.reg_dst;
    assign PCSrc      = ctrl_o.pc_src;
    assign ALUOp      = ALUOP_W'(ctrl_o.alu_op);
    assign state      = RST ? 4'(state_q) : 4'd0;
    assign trap       = RST & trap_q;
    assign trap_cause = RST ? cause_q : 2'b00;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: one instance traps on overflow, a second ignores it;
// both share stimulus and use a 4-cycle memory timeout.
module tb_mc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0, sign = 1'b0, overflow = 1'b0;
    logic       imem_ack = 1'b0, dmem_ack = 1'b0;

    logic       a_imem_req, a_dmem_req, a_PCWre, a_IRWre, a_RegWre, a_mRD, a_mWR;
    logic       a_ALUSrcA, a_ALUSrcB, a_DBDataSrc, a_WrRegDSrc, a_ExtSel, a_ifNeedOf, a_trap;
    logic [1:0] a_RegDst, a_PCSrc, a_trap_cause;
    logic [2:0] a_ALUOp;
    logic [3:0] a_state;

    logic       b_imem_req, b_dmem_req, b_PCWre, b_IRWre, b_RegWre, b_mRD, b_mWR;
    logic       b_ALUSrcA, b_ALUSrcB, b_DBDataSrc, b_WrRegDSrc, b_ExtSel, b_ifNeedOf, b_trap;
    logic [1:0] b_RegDst, b_PCSrc, b_trap_cause;
    logic [2:0] b_ALUOp;
    logic [3:0] b_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_sequencer #(.MEM_TIMEOUT(4), .TRAP_ON_OVF(1'b1), .ALUOP_W(3)) u_dut_a (
        .CLK(clk), .RST(rst), .opcode(opcode), .funct(funct), .zero(zero), .sign(sign),
        .overflow(overflow), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(a_imem_req), .dmem_req(a_dmem_req), .PCWre(a_PCWre), .IRWre(a_IRWre),
        .RegWre(a_RegWre), .mRD(a_mRD), .mWR(a_mWR), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
        .DBDataSrc(a_DBDataSrc), .WrRegDSrc(a_WrRegDSrc), .ExtSel(a_ExtSel),
        .ifNeedOf(a_ifNeedOf), .RegDst(a_RegDst), .PCSrc(a_PCSrc), .ALUOp(a_ALUOp),
        .state(a_state), .trap(a_trap), .trap_cause(a_trap_cause)
    );

    mc_sequencer #(.MEM_TIMEOUT(4), .TRAP_ON_OVF(1'b0), .ALUOP_W(3)) u_dut_b (
        .CLK(clk), .RST(rst), .opcode(opcode), .funct(funct), .zero(zero), .sign(sign),
        .overflow(overflow), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(b_imem_req), .dmem_req(b_dmem_req), .PCWre(b_PCWre), .IRWre(b_IRWre),
        .RegWre(b_RegWre), .mRD(b_mRD), .mWR(b_mWR), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
        .DBDataSrc(b_DBDataSrc), .WrRegDSrc(b_WrRegDSrc), .ExtSel(b_ExtSel),
        .ifNeedOf(b_ifNeedOf), .RegDst(b_RegDst), .PCSrc(b_PCSrc), .ALUOp(b_ALUOp),
        .state(b_state), .trap(b_trap), .trap_cause(b_trap_cause)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a fetched word with an immediate ack, then stop in the ID cycle.
    task automatic fetch_to_id(input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk); opcode = op; funct = fn; imem_ack = 1'b1; #1;
        check("fetch_state_if", a_state, 4'd0);
        check("fetch_irwre", a_IRWre, 1'b1);
        @(negedge clk); imem_ack = 1'b0; #1;
        check("fetch_state_id", a_state, 4'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0; #1;
        check("rst_state", a_state, 4'd0);
        check("rst_imem_req", a_imem_req, 1'b0);
        check("rst_trap", a_trap, 1'b0);
        @(negedge clk); rst = 1'b1; #1;
        check("rel_state", a_state, 4'd0);
        check("rel_imem_req", a_imem_req, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // Reset state
        @(negedge clk); #1;
        check("reset_state", a_state, 4'd0);
        check("reset_imem_req", a_imem_req, 1'b0);
        check("reset_pcwre", a_PCWre, 1'b0);
        check("reset_trap", a_trap, 1'b0);
        check("reset_cause", a_trap_cause, 2'd0);

        // addu with imem_ack three cycles late
        @(negedge clk); rst = 1'b1; opcode = 6'b000000; funct = 6'b100001; #1;
        check("addu_if1_req", a_imem_req, 1'b1);
        check("addu_if1_irwre", a_IRWre, 1'b0);
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk); #1;
            check("addu_ifw_req", a_imem_req, 1'b1);
            check("addu_ifw_irwre", a_IRWre, 1'b0);
            check("addu_ifw_state", a_state, 4'd0);
        end
        @(negedge clk); imem_ack = 1'b1; #1;
        check("addu_if4_req", a_imem_req, 1'b1);
        check("addu_if4_irwre", a_IRWre, 1'b1);
        @(negedge clk); imem_ack = 1'b0; #1;
        check("addu_id_state", a_state, 4'd1);
        check("addu_id_req", a_imem_req, 1'b0);
        check("addu_id_pcwre", a_PCWre, 1'b0);
        @(negedge clk); #1;
        check("addu_exe_state", a_state, 4'd2);
        check("addu_exe_aluop", a_ALUOp, 3'd0);
        check("addu_exe_ifneedof", a_ifNeedOf, 1'b0);
        @(negedge clk); #1;
        check("addu_wb_state", a_state, 4'd3);
        check("addu_wb_regwre", a_RegWre, 1'b1);
        check("addu_wb_regdst", a_RegDst, 2'b10);
        check("addu_wb_pcwre", a_PCWre, 1'b1);
        check("addu_wb_wrregdsrc", a_WrRegDSrc, 1'b1);
        @(negedge clk); #1;
        check("addu_next_state", a_state, 4'd0);
        check("addu_next_regwre", a_RegWre, 1'b0);

        // lw with dmem_ack on the third MEM cycle
        fetch_to_id(6'b100011, 6'd0);
        @(negedge clk); #1;
        check("lw_exe_state", a_state, 4'd5);
        check("lw_exe_alusrcb", a_ALUSrcB, 1'b1);
        check("lw_exe_extsel", a_ExtSel, 1'b1);
        check("lw_exe_aluop", a_ALUOp, 3'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); dmem_ack = (i == 3); #1;
            check("lw_mem_state", a_state, 4'd6);
            check("lw_mem_mrd", a_mRD, 1'b1);
            check("lw_mem_mwr", a_mWR, 1'b0);
            check("lw_mem_req", a_dmem_req, 1'b1);
        end
        @(negedge clk); dmem_ack = 1'b0; #1;
        check("lw_wb_state", a_state, 4'd7);
        check("lw_wb_regwre", a_RegWre, 1'b1);
        check("lw_wb_dbdatasrc", a_DBDataSrc, 1'b1);
        check("lw_wb_pcwre", a_PCWre, 1'b1);
        check("lw_wb_regdst", a_RegDst, 2'b01);
        check("lw_wb_mrd", a_mRD, 1'b0);
        @(negedge clk); #1;
        check("lw_next_state", a_state, 4'd0);

        // Branches: beq taken / not taken, bne taken, bltz taken
        fetch_to_id(6'b000100, 6'd0);
        @(negedge clk); zero = 1'b1; #1;
        check("beq_t_state", a_state, 4'd4);
        check("beq_t_pcsrc", a_PCSrc, 2'b01);
        check("beq_t_pcwre", a_PCWre, 1'b1);
        check("beq_t_aluop", a_ALUOp, 3'd1);
        @(negedge clk); zero = 1'b0; #1;
        check("beq_t_next", a_state, 4'd0);
        fetch_to_id(6'b000100, 6'd0);
        @(negedge clk); #1;
        check("beq_nt_pcsrc", a_PCSrc, 2'b00);
        check("beq_nt_pcwre", a_PCWre, 1'b1);
        fetch_to_id(6'b000101, 6'd0);
        @(negedge clk); #1;
        check("bne_t_pcsrc", a_PCSrc, 2'b01);
        fetch_to_id(6'b000001, 6'd0);
        @(negedge clk); sign = 1'b1; #1;
        check("bltz_t_pcsrc", a_PCSrc, 2'b01);
        @(negedge clk); sign = 1'b0; #1;
        check("bltz_next", a_state, 4'd0);

        // ori: zero-extended immediate, rt destination
        fetch_to_id(6'b001101, 6'd0);
        @(negedge clk); #1;
        check("ori_exe_extsel", a_ExtSel, 1'b0);
        check("ori_exe_alusrcb", a_ALUSrcB, 1'b1);
        check("ori_exe_aluop", a_ALUOp, 3'd3);
        @(negedge clk); #1;
        check("ori_wb_regdst", a_RegDst, 2'b01);
        check("ori_wb_regwre", a_RegWre, 1'b1);

        // jal
        fetch_to_id(6'b000011, 6'd0);
        check("jal_regdst", a_RegDst, 2'b00);
        check("jal_regwre", a_RegWre, 1'b1);
        check("jal_pcsrc", a_PCSrc, 2'b11);
        check("jal_pcwre", a_PCWre, 1'b1);
        check("jal_wrregdsrc", a_WrRegDSrc, 1'b0);
        @(negedge clk); #1;
        check("jal_next", a_state, 4'd0);

        // add with overflow: trapping vs non-trapping instance
        fetch_to_id(6'b000000, 6'b100000);
        @(negedge clk); overflow = 1'b1; #1;
        check("add_exe_state", a_state, 4'd2);
        check("add_exe_ifneedof", a_ifNeedOf, 1'b1);
        @(negedge clk); #1;
        check("ovf_a_regwre", a_RegWre, 1'b0);
        check("ovf_a_pcwre", a_PCWre, 1'b0);
        check("ovf_b_regwre", b_RegWre, 1'b1);
        check("ovf_b_pcwre", b_PCWre, 1'b1);
        @(negedge clk); overflow = 1'b0; #1;
        check("ovf_a_state", a_state, 4'd9);
        check("ovf_a_trap", a_trap, 1'b1);
        check("ovf_a_cause", a_trap_cause, 2'b11);
        check("ovf_b_state", b_state, 4'd0);
        check("ovf_b_trap", b_trap, 1'b0);
        do_reset();

        // Illegal opcode 0x3E, then a late ack is ignored
        fetch_to_id(6'h3E, 6'd0);
        @(negedge clk); #1;
        check("ill_state", a_state, 4'd9);
        check("ill_trap", a_trap, 1'b1);
        check("ill_cause", a_trap_cause, 2'b10);
        @(negedge clk); imem_ack = 1'b1; #1;
        check("ill_late_state", a_state, 4'd9);
        check("ill_late_irwre", a_IRWre, 1'b0);
        check("ill_late_req", a_imem_req, 1'b0);
        @(negedge clk); imem_ack = 1'b0;
        do_reset();

        // halt
        fetch_to_id(6'h3F, 6'd0);
        @(negedge clk); #1;
        check("halt_state", a_state, 4'd8);
        check("halt_trap", a_trap, 1'b0);
        check("halt_req", a_imem_req, 1'b0);
        do_reset();

        // Fetch timeout: cycle 1 was the release cycle, three more without ack
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk); #1;
            check("tmo_wait_state", a_state, 4'd0);
            check("tmo_wait_trap", a_trap, 1'b0);
        end
        @(negedge clk); #1;
        check("tmo_state", a_state, 4'd9);
        check("tmo_trap", a_trap, 1'b1);
        check("tmo_cause", a_trap_cause, 2'b01);
        @(negedge clk); imem_ack = 1'b1; #1;
        check("tmo_late_state", a_state, 4'd9);
        check("tmo_late_irwre", a_IRWre, 1'b0);
        @(negedge clk); imem_ack = 1'b0; #1;
        check("tmo_late_state2", a_state, 4'd9);

        // Ack on the 4th waiting cycle wins over the timeout (j instruction)
        opcode = 6'b000010;
        do_reset();
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk); #1;
        end
        @(negedge clk); imem_ack = 1'b1; #1;
        check("ack4_irwre", a_IRWre, 1'b1);
        @(negedge clk); imem_ack = 1'b0; #1;
        check("ack4_state", a_state, 4'd1);
        check("ack4_trap", a_trap, 1'b0);
        check("j_pcsrc", a_PCSrc, 2'b11);
        check("j_pcwre", a_PCWre, 1'b1);
        @(negedge clk); #1;
        check("j_next", a_state, 4'd0);

        // Reset asserted mid-MEM of a sw
        fetch_to_id(6'b101011, 6'd0);
        @(negedge clk); #1;
        check("sw_exe_state", a_state, 4'd5);
        @(negedge clk); #1;
        check("sw_mem_state", a_state, 4'd6);
        check("sw_mem_req", a_dmem_req, 1'b1);
        check("sw_mem_mwr", a_mWR, 1'b1);
        check("sw_mem_mrd", a_mRD, 1'b0);
        rst = 1'b0; #1;
        check("sw_rst_dmem_req", a_dmem_req, 1'b0);
        check("sw_rst_mwr", a_mWR, 1'b0);
        check("sw_rst_imem_req", a_imem_req, 1'b0);
        check("sw_rst_pcwre", a_PCWre, 1'b0);
        check("sw_rst_state", a_state, 4'd0);
        check("sw_rst_b_mwr", b_mWR, 1'b0);
        @(negedge clk); rst = 1'b1; #1;
        check("sw_rel_state", a_state, 4'd0);
        check("sw_rel_imem_req", a_imem_req, 1'b1);
        check("sw_rel_trap", a_trap, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
